// File: rtl/fetch_stage.sv
// Pre-IF + IF fetch stage: nextpc generation, inst SRAM request, valid/allowin handoff to decode.
// Optional FS_INST_BUF_EN: hold the fetched word in a local buffer across decode stalls.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        fs_to_ds_valid,
  output logic [31:0] fs_pc,
  output logic [31:0] fs_inst,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        r_fs_valid;
  logic [31:0] r_fs_pc;
  logic        w_to_fs_valid;
  logic        w_fs_allowin;
  logic        w_stall;
  logic [31:0] w_seq_pc;
  logic [31:0] w_nextpc;

  assign w_to_fs_valid = ~reset;
  assign w_seq_pc      = r_fs_pc + 32'd4;
  assign w_nextpc      = br_taken ? br_target : w_seq_pc;
  assign w_fs_allowin  = ~r_fs_valid | ds_allowin | br_taken;
  assign w_stall       = r_fs_valid & ~ds_allowin & ~br_taken;

  // The reset cycle must not hand anything to decode, even though r_fs_valid clears only at the edge.
  assign fs_to_ds_valid  = r_fs_valid & ~br_taken & ~reset;
  assign fs_pc           = r_fs_pc;
  assign inst_sram_we    = 4'b0;
  assign inst_sram_wdata = 32'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_valid <= 1'b0;
      r_fs_pc    <= RESET_PC - 32'd4;
    end else if (w_fs_allowin) begin
      r_fs_valid <= w_to_fs_valid;
      r_fs_pc    <= w_nextpc;
    end
  end

`ifdef FS_INST_BUF_EN
  logic        r_buf_valid;
  logic [31:0] r_inst_buf;

  // Capture rdata on the first stall cycle; the SRAM is idle for the rest of the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_valid <= 1'b0;
      r_inst_buf  <= 32'b0;
    end else if (w_stall && !r_buf_valid) begin
      r_buf_valid <= 1'b1;
      r_inst_buf  <= inst_sram_rdata;
    end else if (ds_allowin || br_taken) begin
      r_buf_valid <= 1'b0;
    end
  end

  assign fs_inst        = r_buf_valid ? r_inst_buf : inst_sram_rdata;
  assign inst_sram_en   = w_to_fs_valid & w_fs_allowin;
  assign inst_sram_addr = w_nextpc;
`else
  // Without a buffer, a stalled IF re-reads its own PC so rdata keeps presenting the same word.
  assign fs_inst        = inst_sram_rdata;
  assign inst_sram_en   = w_to_fs_valid;
  assign inst_sram_addr = w_stall ? r_fs_pc : w_nextpc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed handshake scenarios plus randomized traffic
// against a cycle-level model of the instruction stream seen by decode.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h1c000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic        br_taken;
  logic [31:0] br_target;
  logic        fs_to_ds_valid;
  logic [31:0] fs_pc;
  logic [31:0] fs_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_vec = 0;
  int n_err = 0;

  // Model: the PC currently in IF and whether it is live.
  logic        m_valid;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_taken(br_taken),
    .br_target(br_target), .fs_to_ds_valid(fs_to_ds_valid), .fs_pc(fs_pc),
    .fs_inst(fs_inst), .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_3c3c;
  endfunction

  // Synchronous SRAM: output holds when not enabled.
  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);

  task automatic drive(input logic rst, input logic ds, input logic br, input logic [31:0] tgt);
    reset = rst; ds_allowin = ds; br_taken = br; br_target = tgt;
    @(negedge clk);
  endtask

  // Advance one clock and apply the handshake rules to the model.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_pc = RPC - 32'd4;
    end else if (!m_valid || ds_allowin || br_taken) begin
      m_pc    = br_taken ? br_target : m_pc + 32'd4;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", fs_to_ds_valid); end
    n_vec++; if (inst_sram_en !== 1'b0) begin n_err++; $display("FAIL reset_en got=%b exp=0", inst_sram_en); end
    n_vec++; if (fs_pc !== RPC - 32'd4) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", fs_pc, RPC - 32'd4); end
    n_vec++; if (inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'b0) begin
      n_err++; $display("FAIL sram_we_wdata got=%h/%h exp=0/0", inst_sram_we, inst_sram_wdata); end
    tick();
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      n_vec++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== RPC + 32'(4*k)) begin
        n_err++; $display("FAIL seq_req%0d got=%b/%h exp=1/%h", k, inst_sram_en, inst_sram_addr, RPC + 32'(4*k)); end
      n_vec++; if (fs_to_ds_valid !== (k > 0)) begin
        n_err++; $display("FAIL seq_valid%0d got=%b exp=%b", k, fs_to_ds_valid, k > 0); end
      if (k > 0) begin
        n_vec++; if (fs_pc !== RPC + 32'(4*(k-1)) || fs_inst !== mem_word(RPC + 32'(4*(k-1)))) begin
          n_err++; $display("FAIL seq_pc%0d got=%h/%h exp=%h", k, fs_pc, fs_inst, RPC + 32'(4*(k-1))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (fs_pc !== 32'h1c000008 || fs_inst !== mem_word(32'h1c000008) || fs_to_ds_valid !== 1'b1) begin
        n_err++; $display("FAIL stall_hold%0d got=%h/%h/%b exp=1c000008/%h/1", k, fs_pc, fs_inst, fs_to_ds_valid, mem_word(32'h1c000008)); end
`ifdef FS_INST_BUF_EN
      n_vec++; if (inst_sram_en !== 1'b0) begin n_err++; $display("FAIL stall_en%0d got=%b exp=0", k, inst_sram_en); end
`else
      n_vec++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000008) begin
        n_err++; $display("FAIL stall_reread%0d got=%b/%h exp=1/1c000008", k, inst_sram_en, inst_sram_addr); end
`endif
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00000c) begin
      n_err++; $display("FAIL stall_resume got=%b/%h exp=1/1c00000c", inst_sram_en, inst_sram_addr); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
  endtask

  task automatic test_branch();
    drive(1'b0, 1'b1, 1'b1, 32'h1c000100);
    n_vec++; if (fs_pc !== 32'h1c000010 || fs_to_ds_valid !== 1'b0) begin
      n_err++; $display("FAIL br_cancel got=%h/%b exp=1c000010/0", fs_pc, fs_to_ds_valid); end
    n_vec++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000100) begin
      n_err++; $display("FAIL br_req got=%b/%h exp=1/1c000100", inst_sram_en, inst_sram_addr); end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0, 32'h0);
      n_vec++; if (fs_to_ds_valid !== 1'b1 || fs_pc !== 32'h1c000100 + 32'(4*k) || fs_inst !== mem_word(32'h1c000100 + 32'(4*k))) begin
        n_err++; $display("FAIL br_target%0d got=%b/%h exp=1/%h", k, fs_to_ds_valid, fs_pc, 32'h1c000100 + 32'(4*k)); end
      tick();
    end
  endtask

  task automatic test_branch_stall();
    logic [31:0] stuck;
    drive(1'b0, 1'b0, 1'b0, 32'h0); stuck = m_pc; tick();
    drive(1'b0, 1'b0, 1'b1, 32'h1c000200);
    n_vec++; if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c000200) begin
      n_err++; $display("FAIL brst_redirect got=%b/%b/%h exp=0/1/1c000200 (stalled %h)", fs_to_ds_valid, inst_sram_en, inst_sram_addr, stuck); end
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0);
      n_vec++; if (fs_pc !== 32'h1c000200 || fs_inst !== mem_word(32'h1c000200) || fs_to_ds_valid !== 1'b1) begin
        n_err++; $display("FAIL brst_newinst%0d got=%h/%h exp=1c000200/%h", k, fs_pc, fs_inst, mem_word(32'h1c000200)); end
      tick();
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0); tick();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 32'h0); tick();
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    n_vec++; if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin
      n_err++; $display("FAIL rstmid got=%b/%b exp=0/0", fs_to_ds_valid, inst_sram_en); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== RPC) begin
      n_err++; $display("FAIL rstmid_restart got=%b/%b/%h exp=0/1/%h", fs_to_ds_valid, inst_sram_en, inst_sram_addr, RPC); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fs_pc !== RPC || fs_inst !== mem_word(RPC)) begin
      n_err++; $display("FAIL rstmid_first got=%h/%h exp=%h/%h", fs_pc, fs_inst, RPC, mem_word(RPC)); end
    tick();
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 1'b1, 32'hfffffffc); tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fs_pc !== 32'hfffffffc || inst_sram_addr !== 32'h0 || inst_sram_en !== 1'b1) begin
      n_err++; $display("FAIL wrap_req got=%h/%h exp=fffffffc/00000000", fs_pc, inst_sram_addr); end
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    n_vec++; if (fs_pc !== 32'h0 || fs_inst !== mem_word(32'h0)) begin
      n_err++; $display("FAIL wrap_pc got=%h/%h exp=0/%h", fs_pc, fs_inst, mem_word(32'h0)); end
    tick();
  endtask

  task automatic test_random();
    logic r, d, b, stall;
    logic [31:0] t, exp_addr;
    for (int k = 0; k < 600; k++) begin
      r = ($urandom_range(0, 59) == 0);
      d = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 7) == 0);
      t = {$urandom(), 2'b00} & 32'hffff_fffc;
      drive(r, d, b, t);
      stall = m_valid & ~d & ~b;
      exp_addr = b ? t : m_pc + 32'd4;
      n_vec++; if (fs_to_ds_valid !== (m_valid & ~b & ~r)) begin
        n_err++; $display("FAIL rnd_valid%0d got=%b exp=%b", k, fs_to_ds_valid, m_valid & ~b & ~r); end
      if (m_valid && !r) begin
        n_vec++; if (fs_pc !== m_pc || fs_inst !== mem_word(m_pc)) begin
          n_err++; $display("FAIL rnd_pc%0d got=%h/%h exp=%h/%h", k, fs_pc, fs_inst, m_pc, mem_word(m_pc)); end
      end
      if (r) begin
        n_vec++; if (inst_sram_en !== 1'b0) begin n_err++; $display("FAIL rnd_rsten%0d got=%b exp=0", k, inst_sram_en); end
      end else if (stall) begin
`ifdef FS_INST_BUF_EN
        n_vec++; if (inst_sram_en !== 1'b0) begin n_err++; $display("FAIL rnd_stallen%0d got=%b exp=0", k, inst_sram_en); end
`else
        n_vec++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== m_pc) begin
          n_err++; $display("FAIL rnd_reread%0d got=%b/%h exp=1/%h", k, inst_sram_en, inst_sram_addr, m_pc); end
`endif
      end else begin
        n_vec++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== exp_addr) begin
          n_err++; $display("FAIL rnd_req%0d got=%b/%h exp=1/%h", k, inst_sram_en, inst_sram_addr, exp_addr); end
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    m_valid = 1'b0; m_pc = RPC - 32'd4;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
